// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM encoding and default widths.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter: counts data grants made while fetch waits; built only with MEM_ARB_STARVE_GUARD_EN.
`ifdef MEM_ARB_STARVE_GUARD_EN
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic fetch_waiting,
  output logic limit_hit
);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Saturates so a stray extra increment can never wrap back below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (fetch_grant) begin
      cnt_d = '0;
    end else if (data_grant && fetch_waiting && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit = (cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter for one shared memory port, data has priority.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_e        dbg_state
);

  // Handshake: a requester raises req with its fields stable and holds them until
  // it sees a one-cycle ack; the memory side sees mem_req held until a one-cycle mem_ack.
  arb_state_e        state_q, state_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              fetch_grant;
  logic              data_grant;
  logic              force_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic limit_hit;

  arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk           (clk),
    .rst           (rst),
    .data_grant    (data_grant),
    .fetch_grant   (fetch_grant),
    .fetch_waiting (i_req),
    .limit_hit     (limit_hit)
  );

  assign force_fetch = i_req & limit_hit;
`else
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_grant = 1'b0;
    data_grant  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Data is the older instruction in the pipe, so it wins ties.
        if (d_req && !force_fetch) begin
          data_grant  = 1'b1;
          state_d     = ST_D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_req) begin
          fetch_grant = 1'b1;
          state_d     = ST_I_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
        end
      end
      ST_I_BUSY: begin
        if (mem_ack) begin
          i_rdata_d = mem_rdata;
          i_ack_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_D_BUSY: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          d_ack_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_stall  = i_req & ~i_ack_q;
  assign mem_stall = d_req & ~d_ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              if_stall;
  logic              mem_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  arb_state_e        dbg_state;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .if_stall  (if_stall),
    .mem_stall (mem_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int   forced_lat = 0;
  int   lat_cnt    = 0;
  int   lat_target = 1;
  bit   fixed_rdata_en = 1'b0;
  logic [DATA_W-1:0] fixed_rdata = '0;
  bit   spur_en    = 1'b0;
  bit   spur_force = 1'b0;

  // Advance one cycle: wait past the edge, then let the memory react to this cycle's mem_req.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (mem_req && !mem_ack) begin
      if (lat_cnt == 0) lat_target = (forced_lat != 0) ? forced_lat : int'($urandom_range(1, 4));
      lat_cnt++;
      mem_ack = (lat_cnt == lat_target);
      if (mem_ack) lat_cnt = 0;
    end else begin
      mem_ack = spur_force || (spur_en && ($urandom_range(0, 7) == 0));
    end
    mem_rdata = fixed_rdata_en ? fixed_rdata : DATA_W'($urandom);
  endtask

  task automatic wait_ack(input string name, input bit want_i, input bit want_d, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      step();
      n++;
      if ((want_i && i_ack) || (want_d && d_ack)) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // Transaction view: one transaction at a time; after memory answers, one ack cycle, one idle cycle.
  bit                m_active = 1'b0;
  bit                m_done   = 1'b0;
  bit                m_fetch  = 1'b0;
  bit                starve_force;
`ifdef MEM_ARB_STARVE_GUARD_EN
  int                m_starve = 0;
`endif
  logic              exp_i_ack = 1'b0;
  logic              exp_d_ack = 1'b0;
  logic [DATA_W-1:0] exp_i_rdata = '0;
  logic [DATA_W-1:0] exp_d_rdata = '0;
  logic              exp_mem_req = 1'b0;
  logic              exp_mem_we = 1'b0;
  logic [ADDR_W-1:0] exp_mem_addr = '0;
  logic [DATA_W-1:0] exp_mem_wdata = '0;

  initial forever begin
    @(negedge clk);
    check("i_ack", 32'(i_ack), 32'(exp_i_ack));
    check("d_ack", 32'(d_ack), 32'(exp_d_ack));
    check("i_rdata", i_rdata, exp_i_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    check("mem_req", 32'(mem_req), 32'(exp_mem_req));
    check("if_stall", 32'(if_stall), 32'(i_req & ~exp_i_ack));
    check("mem_stall", 32'(mem_stall), 32'(d_req & ~exp_d_ack));
    check("ack_overlap", 32'(i_ack & d_ack), 32'd0);
    if (exp_mem_req) begin
      check("mem_we", 32'(mem_we), 32'(exp_mem_we));
      check("mem_addr", mem_addr, exp_mem_addr);
      if (exp_mem_we) check("mem_wdata", mem_wdata, exp_mem_wdata);
    end
    // Predict the outputs after the coming edge from the inputs now stable.
    if (rst) begin
      m_active = 1'b0;
      m_done = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      m_starve = 0;
`endif
      exp_i_ack = 1'b0; exp_d_ack = 1'b0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      exp_mem_req = 1'b0; exp_mem_we = 1'b0;
      exp_mem_addr = '0; exp_mem_wdata = '0;
    end else begin
      exp_i_ack = 1'b0;
      exp_d_ack = 1'b0;
      if (m_active && m_done) begin
        m_active = 1'b0;
        m_done = 1'b0;
      end else if (m_active) begin
        if (mem_ack) begin
          m_done = 1'b1;
          exp_mem_req = 1'b0;
          if (m_fetch) begin
            exp_i_ack = 1'b1;
            exp_i_rdata = mem_rdata;
          end else begin
            exp_d_ack = 1'b1;
            if (!exp_mem_we) exp_d_rdata = mem_rdata;
          end
        end
      end else begin
        starve_force = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_force = i_req && (m_starve == int'(STARVE_LIMIT));
`endif
        if (d_req && !starve_force) begin
          m_active = 1'b1; m_fetch = 1'b0;
          exp_mem_req = 1'b1; exp_mem_we = d_we;
          exp_mem_addr = d_addr; exp_mem_wdata = d_wdata;
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (i_req) m_starve++;
`endif
        end else if (i_req) begin
          m_active = 1'b1; m_fetch = 1'b1;
          exp_mem_req = 1'b1; exp_mem_we = 1'b0;
          exp_mem_addr = i_addr;
`ifdef MEM_ARB_STARVE_GUARD_EN
          m_starve = 0;
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int mreq_cycles;
    int dcyc;
    int icyc;
    int dacks;
    int seen;
    bit got_i;

    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) step();
    check("rst_i_ack", 32'(i_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Fetch only, L=2.
    forced_lat = 2; fixed_rdata_en = 1'b1; fixed_rdata = 32'h2001_0005;
    i_req = 1'b1; i_addr = 32'h0000_0010;
    n = 0; mreq_cycles = 0; got_i = 1'b0;
    while (!got_i && n < 40) begin
      step();
      n++;
      if (mem_req) begin
        mreq_cycles++;
        check("fetch_mem_addr", mem_addr, 32'h10);
        check("fetch_mem_we", 32'(mem_we), 32'd0);
      end
      if (i_ack) got_i = 1'b1;
    end
    check("fetch_ack_lat", 32'(n), 32'd3);
    check("fetch_memreq_cycles", 32'(mreq_cycles), 32'd2);
    check("fetch_rdata", i_rdata, 32'h2001_0005);
    i_req = 1'b0;
    step();

    // Data write, L=1.
    forced_lat = 1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    step();
    check("wr_mem_req", 32'(mem_req), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h40);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_ack("wr_timeout", 1'b0, 1'b1, n);
    check("wr_ack_lat", 32'(n + 1), 32'd2);
    check("wr_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();

    // Both raised together, L=1: data first, then fetch.
    fixed_rdata = 32'h1234_5678;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    n = 0; dcyc = -1; icyc = -1;
    while ((dcyc < 0 || icyc < 0) && n < 30) begin
      step();
      n++;
      if (d_ack && dcyc < 0) begin dcyc = n; d_req = 1'b0; end
      if (i_ack && icyc < 0) begin icyc = n; i_req = 1'b0; end
    end
    check("both_d_ack_cycle", 32'(dcyc), 32'd2);
    check("both_i_ack_cycle", 32'(icyc), 32'd5);
    check("both_d_rdata", d_rdata, 32'h1234_5678);
    step();

    // Data held continuously with fetch waiting.
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    n = 0; dacks = 0; got_i = 1'b0;
    while (!got_i && dacks < 10 && n < 80) begin
      step();
      n++;
      if (d_ack) dacks++;
      if (i_ack) got_i = 1'b1;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_fetch_granted", 32'(got_i), 32'd1);
    check("starve_dacks_before", 32'(dacks), 32'(STARVE_LIMIT));
`else
    check("strict_no_fetch", 32'(got_i), 32'd0);
    check("strict_dacks", 32'(dacks), 32'd10);
`endif
    if (got_i) begin
      i_req = 1'b0;
      wait_ack("starve_drain_d", 1'b0, 1'b1, n);
      d_req = 1'b0;
    end else begin
      d_req = 1'b0;
      wait_ack("starve_drain_i", 1'b1, 1'b0, n);
      i_req = 1'b0;
    end
    step();

    // Reset during a fetch, L=3.
    forced_lat = 3;
    i_req = 1'b1; i_addr = 32'h500;
    step();
    check("mid_busy_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1; i_req = 1'b0;
    step();
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_i_ack", 32'(i_ack), 32'd0);
    check("mid_rst_i_rdata", i_rdata, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      step();
      if (i_ack) seen++;
    end
    check("mid_rst_no_ack", 32'(seen), 32'd0);

    // Spurious mem_ack while idle.
    fixed_rdata = 32'hFFFF_FFFF;
    spur_force = 1'b1;
    step();
    spur_force = 1'b0;
    repeat (2) begin
      step();
      check("spur_i_ack", 32'(i_ack), 32'd0);
      check("spur_d_ack", 32'(d_ack), 32'd0);
      check("spur_state", 32'(dbg_state), 32'd0);
      check("spur_i_rdata", i_rdata, 32'd0);
      check("spur_d_rdata", d_rdata, 32'd0);
    end

    // Random traffic with random latency, spurious acks and occasional reset.
    forced_lat = 0; fixed_rdata_en = 1'b0; spur_en = 1'b1;
    repeat (1500) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (i_req) begin
        if (i_ack) begin
          if ($urandom_range(0, 1) == 1) i_addr = ADDR_W'($urandom) & ~32'h3;
          else i_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        i_req = 1'b1;
        i_addr = ADDR_W'($urandom) & ~32'h3;
      end
      if (d_req) begin
        if (d_ack) begin
          if ($urandom_range(0, 1) == 1) begin
            d_we = 1'($urandom_range(0, 1));
            d_addr = ADDR_W'($urandom) & ~32'h3;
            d_wdata = DATA_W'($urandom);
          end else begin
            d_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = ADDR_W'($urandom) & ~32'h3;
        d_wdata = DATA_W'($urandom);
      end
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; spur_en = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
